// File: rtl/debug_cmd_sync_queue.sv
// System-clock side of the JTAG debug slave: synchronises vs_uir/vs_udr, captures IR/DR and queues commands.
// Optional macro DEBUG_CMD_TIMESTAMP_EN adds a free-running timestamp stored with each queued command.
`timescale 1ns/1ps
module debug_cmd_sync_queue #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int ACT_BIT     = 35,
    parameter int CNT_W       = 8
`ifdef DEBUG_CMD_TIMESTAMP_EN
    ,
    parameter int TS_W        = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DR_W-1:0]          sr,
    input  logic [IR_W-1:0]          ir_in,
    input  logic                     vs_uir,
    input  logic                     vs_udr,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [DR_W-1:0]          cmd_data,
    output logic                     cmd_action,
    output logic                     uir_seen,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     ovf_clr
`ifdef DEBUG_CMD_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]          cmd_ts
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [SYNC_STAGES-1:0] uir_sync, udr_sync, sync_vld;
    logic                   uir_d, udr_d, uir_armed, udr_armed;
    logic                   uir_pulse, udr_pulse;

    logic [IR_W-1:0]        ir_reg;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [IR_W-1:0]        mem_ir   [DEPTH];
    logic [DR_W-1:0]        mem_data [DEPTH];

    logic                   pop, full, push_ok, drop;
    logic [IR_W-1:0]        push_ir;
    logic [LVL_W-1:0]       level_after_pop;

`ifdef DEBUG_CMD_TIMESTAMP_EN
    logic [TS_W-1:0]        ts_cnt;
    logic [TS_W-1:0]        mem_ts [DEPTH];
`endif

    // sync_vld tracks when the chains hold real samples, so a strobe held
    // high through reset release never looks like a fresh low-to-high edge.
    assign uir_pulse = uir_sync[SYNC_STAGES-1] & ~uir_d & uir_armed;
    assign udr_pulse = udr_sync[SYNC_STAGES-1] & ~udr_d & udr_armed;
    assign uir_seen  = uir_pulse;

    assign cmd_valid  = (level != '0);
    assign cmd_action = cmd_data[ACT_BIT];

    always_comb begin
        pop             = cmd_valid & cmd_ready;
        full            = (level == LVL_W'(DEPTH));
        push_ok         = udr_pulse & (~full | pop);
        drop            = udr_pulse & full & ~pop;
        push_ir         = uir_pulse ? ir_in : ir_reg;
        level_after_pop = level - LVL_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uir_sync  <= '0;
            udr_sync  <= '0;
            sync_vld  <= '0;
            uir_d     <= 1'b0;
            udr_d     <= 1'b0;
            uir_armed <= 1'b0;
            udr_armed <= 1'b0;
            ir_reg    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            cmd_ir    <= '0;
            cmd_data  <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
`ifdef DEBUG_CMD_TIMESTAMP_EN
            ts_cnt    <= '0;
            cmd_ts    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // value of its neighbour, which is what makes the chain shift.
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            uir_d     <= uir_sync[SYNC_STAGES-1];
            udr_d     <= udr_sync[SYNC_STAGES-1];
            uir_armed <= uir_armed | (sync_vld[SYNC_STAGES-1] & ~uir_sync[SYNC_STAGES-1]);
            udr_armed <= udr_armed | (sync_vld[SYNC_STAGES-1] & ~udr_sync[SYNC_STAGES-1]);

            if (uir_pulse)
                ir_reg <= ir_in;

            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)
                level <= level + LVL_W'(1);
            else if (!push_ok && pop)
                level <= level - LVL_W'(1);

            // Head registers: load the incoming command when it becomes the head,
            // otherwise the next stored entry on a pop; hold when draining to empty.
            if (push_ok && level_after_pop == '0) begin
                cmd_ir   <= push_ir;
                cmd_data <= sr;
`ifdef DEBUG_CMD_TIMESTAMP_EN
                cmd_ts   <= ts_cnt;
`endif
            end else if (pop && level_after_pop != '0) begin
                cmd_ir   <= mem_ir[rd_ptr + PTR_W'(1)];
                cmd_data <= mem_data[rd_ptr + PTR_W'(1)];
`ifdef DEBUG_CMD_TIMESTAMP_EN
                cmd_ts   <= mem_ts[rd_ptr + PTR_W'(1)];
`endif
            end

            if (drop) begin
                overflow <= 1'b1;
                if (ovf_clr)
                    drop_cnt <= CNT_W'(1);
                else if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + CNT_W'(1);
            end else if (ovf_clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end

`ifdef DEBUG_CMD_TIMESTAMP_EN
            ts_cnt <= ts_cnt + TS_W'(1);
`endif
        end
    end

    // NOTE: queue storage has no reset; the pointers and level define which
    // entries are meaningful, so flushing only needs those cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_ir[wr_ptr]   <= push_ir;
            mem_data[wr_ptr] <= sr;
`ifdef DEBUG_CMD_TIMESTAMP_EN
            mem_ts[wr_ptr]   <= ts_cnt;
`endif
        end
    end

endmodule
